// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared router types: output-port encoding, the idle-port
//                marker and the per-output switch-allocation state.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Number of router ports: N, E, S, W, LOCAL
    localparam int c_num_router_ports = 5;

    // Width of the output-port encoding
    localparam int c_port_w = 3;

    // Requested output port of an input unit; NONE_PORT means no target
    typedef enum logic [c_port_w-1:0] {
        PORT_NORTH = 3'd0,
        PORT_EAST  = 3'd1,
        PORT_SOUTH = 3'd2,
        PORT_WEST  = 3'd3,
        PORT_LOCAL = 3'd4,
        NONE_PORT  = 3'd7
    } PORT_t;

    // Per-output switch allocation state
    typedef enum logic [0:0] {
        FREE      = 1'b0,
        ALLOCATED = 1'b1
    } SW_ALLOC_STATE_t;

endpackage : router_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Scans the request vector
//                starting at the priority pointer, wrapping at NUM_PORTS,
//                and returns a one-hot grant (all zero when nothing requests).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [SEL_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_grant
);

    // One extra bit holds ptr + offset before the wrap correction
    localparam int c_sum_w = SEL_W + 1;

    logic [c_sum_w-1:0] w_sum;
    logic [SEL_W-1:0]   w_idx;
    logic               w_found;

    // First requester at or after the pointer, in circular order, wins
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_sum = {1'b0, i_ptr} + c_sum_w'(k);
            if (w_sum >= c_sum_w'(NUM_PORTS)) begin
                w_sum = w_sum - c_sum_w'(NUM_PORTS);
            end
            w_idx = w_sum[SEL_W-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : switch_allocator
//  Description : Router switch allocator. Each output port owns a FREE /
//                ALLOCATED state machine and a round-robin pointer. A FREE
//                output grants one requesting input; the grant persists until
//                the owner signals its tail flit or withdraws its request.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator
    import router_pkg::*;
#(
    parameter int NUM_PORTS = c_num_router_ports,
    parameter int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0]            i_switch_req,
    input  PORT_t [NUM_PORTS-1:0]           i_target_port,
    input  logic [NUM_PORTS-1:0]            i_packet_done,
    output logic [NUM_PORTS-1:0]            o_switch_ack,
    output logic [NUM_PORTS-1:0][SEL_W-1:0] o_xbar_sel,
    output logic [NUM_PORTS-1:0]            o_out_valid
);

    // Per-output registered state
    SW_ALLOC_STATE_t    r_state     [NUM_PORTS];
    logic [SEL_W-1:0]   r_ptr       [NUM_PORTS];
    logic [SEL_W-1:0]   r_sel       [NUM_PORTS];

    // Per-output next-state values
    SW_ALLOC_STATE_t    w_state_nxt [NUM_PORTS];
    logic [SEL_W-1:0]   w_ptr_nxt   [NUM_PORTS];
    logic [SEL_W-1:0]   w_sel_nxt   [NUM_PORTS];

    // Per-output arbitration signals
    logic [NUM_PORTS-1:0] w_req     [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_grant   [NUM_PORTS];
    logic [SEL_W-1:0]     w_win_idx [NUM_PORTS];
    logic                 w_release [NUM_PORTS];

    // Inputs currently holding a grant (decoded from registered state only)
    logic [NUM_PORTS-1:0] w_ack;

    // Request matrix: an input competes for its target only while unacked
    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_req[j] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_req[j][i] = i_switch_req[i]
                              && (i_target_port[i] != NONE_PORT)
                              && (i_target_port[i] == c_port_w'(j))
                              && !w_ack[i];
            end
        end
    end

    // One round-robin arbiter per output port
    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out_arb
            rr_arbiter #(
                .NUM_PORTS (NUM_PORTS),
                .SEL_W     (SEL_W)
            ) u_rr_arbiter (
                .i_req   (w_req[g]),
                .i_ptr   (r_ptr[g]),
                .o_grant (w_grant[g])
            );
        end
    endgenerate

    // Next-state: grant a FREE output, release an ALLOCATED one on done/abort
    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_state_nxt[j] = r_state[j];
            w_ptr_nxt[j]   = r_ptr[j];
            w_sel_nxt[j]   = r_sel[j];
            w_win_idx[j]   = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_grant[j][i]) begin
                    w_win_idx[j] = SEL_W'(i);
                end
            end
            // Owner finishing its packet or dropping its request frees the port
            w_release[j] = i_packet_done[r_sel[j]] || !i_switch_req[r_sel[j]];

            case (r_state[j])
                FREE: begin
                    if (|w_grant[j]) begin
                        w_state_nxt[j] = ALLOCATED;
                        w_sel_nxt[j]   = w_win_idx[j];
                        w_ptr_nxt[j]   = (w_win_idx[j] == SEL_W'(NUM_PORTS - 1))
                                         ? '0 : (w_win_idx[j] + SEL_W'(1));
                    end
                end
                ALLOCATED: begin
                    if (w_release[j]) begin
                        w_state_nxt[j] = FREE;
                    end
                end
                default: begin
                    w_state_nxt[j] = FREE;
                end
            endcase
        end
    end

    // State, pointer and crossbar-select registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                r_state[j] <= FREE;
                r_ptr[j]   <= '0;
                r_sel[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                r_state[j] <= w_state_nxt[j];
                r_ptr[j]   <= w_ptr_nxt[j];
                r_sel[j]   <= w_sel_nxt[j];
            end
        end
    end

    // Outputs decoded from registered state: valid, select and per-input ack
    always_comb begin
        w_ack = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            o_out_valid[j] = (r_state[j] == ALLOCATED);
            o_xbar_sel[j]  = r_sel[j];
            for (int i = 0; i < NUM_PORTS; i++) begin
                if ((r_state[j] == ALLOCATED) && (r_sel[j] == SEL_W'(i))) begin
                    w_ack[i] = 1'b1;
                end
            end
        end
        o_switch_ack = w_ack;
    end

endmodule : switch_allocator
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_allocator
//  Description : Self-checking bench for switch_allocator. Cycle vectors are
//                applied from a table; expected outputs are queued when the
//                stimulus is driven and popped when the DUT output is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;
    import router_pkg::*;

    localparam logic [2:0] PN = 3'd0;
    localparam logic [2:0] PE = 3'd1;
    localparam logic [2:0] PS = 3'd2;
    localparam logic [2:0] PW = 3'd3;
    localparam logic [2:0] PL = 3'd4;
    localparam logic [2:0] PX = 3'd7;

    typedef struct {
        logic [4:0]  req;
        logic [14:0] tgt;
        logic [4:0]  done;
        logic [4:0]  ack;
        logic [4:0]  valid;
        logic [14:0] sel;
        string       name;
    } vec_t;

    typedef struct {
        logic [4:0]  ack;
        logic [4:0]  valid;
        logic [14:0] sel;
        bit          sel_all;
        string       name;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [4:0]           sw_req;
    PORT_t [4:0]          tgt;
    logic [4:0]           pkt_done;
    logic [4:0]           ack;
    logic [4:0][2:0]      xbar_sel;
    logic [4:0]           out_valid;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    switch_allocator #(
        .NUM_PORTS (5),
        .SEL_W     (3)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_switch_req  (sw_req),
        .i_target_port (tgt),
        .i_packet_done (pkt_done),
        .o_switch_ack  (ack),
        .o_xbar_sel    (xbar_sel),
        .o_out_valid   (out_valid)
    );

    function automatic logic [14:0] mk5(logic [2:0] a0, logic [2:0] a1, logic [2:0] a2,
                                        logic [2:0] a3, logic [2:0] a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    function automatic vec_t V(logic [4:0] r, logic [14:0] t, logic [4:0] d,
                               logic [4:0] a, logic [4:0] v, logic [14:0] s, string n);
        vec_t x;
        x.req = r; x.tgt = t; x.done = d; x.ack = a; x.valid = v; x.sel = s; x.name = n;
        return x;
    endfunction

    task automatic apply_inputs(logic [4:0] r, logic [14:0] t, logic [4:0] d);
        sw_req   = r;
        pkt_done = d;
        for (int i = 0; i < 5; i++) begin
            tgt[i] = PORT_t'(t[3*i +: 3]);
        end
    endtask

    task automatic push_exp(logic [4:0] a, logic [4:0] v, logic [14:0] s, bit all, string n);
        exp_t e;
        e.ack = a; e.valid = v; e.sel = s; e.sel_all = all; e.name = n;
        sb.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t        e;
        logic [14:0] m;
        logic [14:0] got;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: no expected entry for sampled output");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (ack !== e.ack) begin
            errors++;
            $display("FAIL %s ack: got %b expected %b", e.name, ack, e.ack);
        end
        checks++;
        if (out_valid !== e.valid) begin
            errors++;
            $display("FAIL %s valid: got %b expected %b", e.name, out_valid, e.valid);
        end
        for (int j = 0; j < 5; j++) begin
            m[3*j +: 3] = (e.sel_all || e.valid[j]) ? 3'b111 : 3'b000;
        end
        got = xbar_sel;
        if (m != '0) begin
            checks++;
            if ((got & m) !== (e.sel & m)) begin
                errors++;
                $display("FAIL %s sel: got %h expected %h (mask %h)", e.name, got & m, e.sel & m, m);
            end
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, sample after the edge
    task automatic run_vec(vec_t v);
        @(negedge clk);
        apply_inputs(v.req, v.tgt, v.done);
        push_exp(v.ack, v.valid, v.sel, 1'b0, v.name);
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    initial begin
        logic [14:0] t_e;
        logic [14:0] t_s;
        logic [14:0] t_w;
        logic [14:0] t_par;
        logic [14:0] t_none;
        logic [14:0] t_rst;
        logic [14:0] t_ee;

        t_e    = mk5(PE, PX, PX, PX, PX);
        t_s    = mk5(PX, PS, PS, PS, PX);
        t_w    = mk5(PW, PX, PX, PW, PW);
        t_par  = mk5(PN, PE, PL, PX, PX);
        t_none = mk5(PN, PE, PL, PX, PX);
        t_rst  = mk5(PX, PE, PN, PX, PX);
        t_ee   = mk5(PE, PX, PX, PE, PX);

        // Single request on E, then release by done
        tbl.push_back(V(5'b00001, t_e, 5'b00000, 5'b00001, 5'b00010, mk5(0,0,0,0,0), "single_grant"));
        tbl.push_back(V(5'b00001, t_e, 5'b00000, 5'b00001, 5'b00010, mk5(0,0,0,0,0), "single_hold"));
        tbl.push_back(V(5'b00000, t_e, 5'b00001, 5'b00000, 5'b00000, '0, "single_done"));
        tbl.push_back(V(5'b00000, t_e, 5'b00000, 5'b00000, 5'b00000, '0, "idle"));
        // Contention on S: order 1, 2, 3
        tbl.push_back(V(5'b01110, t_s, 5'b00000, 5'b00010, 5'b00100, mk5(0,0,1,0,0), "cont_win1"));
        tbl.push_back(V(5'b01110, t_s, 5'b00000, 5'b00010, 5'b00100, mk5(0,0,1,0,0), "cont_hold1"));
        tbl.push_back(V(5'b01100, t_s, 5'b00010, 5'b00000, 5'b00000, '0, "cont_done1"));
        tbl.push_back(V(5'b01100, t_s, 5'b00000, 5'b00100, 5'b00100, mk5(0,0,2,0,0), "cont_win2"));
        tbl.push_back(V(5'b01000, t_s, 5'b00100, 5'b00000, 5'b00000, '0, "cont_done2"));
        tbl.push_back(V(5'b01000, t_s, 5'b00000, 5'b01000, 5'b00100, mk5(0,0,3,0,0), "cont_win3"));
        tbl.push_back(V(5'b00000, t_s, 5'b01000, 5'b00000, 5'b00000, '0, "cont_done3"));
        // Wrap-around on W: move pointer to 4, then 4 wins, then 0 wins
        tbl.push_back(V(5'b01000, t_w, 5'b00000, 5'b01000, 5'b01000, mk5(0,0,0,3,0), "wrap_setup"));
        tbl.push_back(V(5'b00000, t_w, 5'b01000, 5'b00000, 5'b00000, '0, "wrap_setup_done"));
        tbl.push_back(V(5'b10001, t_w, 5'b00000, 5'b10000, 5'b01000, mk5(0,0,0,4,0), "wrap_win4"));
        tbl.push_back(V(5'b10001, t_w, 5'b10000, 5'b00000, 5'b00000, '0, "wrap_done4"));
        tbl.push_back(V(5'b10001, t_w, 5'b00000, 5'b00001, 5'b01000, mk5(0,0,0,0,0), "wrap_win0"));
        tbl.push_back(V(5'b10000, t_w, 5'b00001, 5'b00000, 5'b00000, '0, "wrap_done0"));
        tbl.push_back(V(5'b10000, t_w, 5'b00000, 5'b10000, 5'b01000, mk5(0,0,0,4,0), "wrap_win4b"));
        tbl.push_back(V(5'b00000, t_w, 5'b10000, 5'b00000, 5'b00000, '0, "wrap_done4b"));
        // Parallel grants, abort, stray done, NONE_PORT request
        tbl.push_back(V(5'b00111, t_par, 5'b00000, 5'b00111, 5'b10011, mk5(0,1,0,0,2), "parallel"));
        tbl.push_back(V(5'b00101, t_par, 5'b00000, 5'b00101, 5'b10001, mk5(0,0,0,0,2), "abort_e"));
        tbl.push_back(V(5'b00101, t_par, 5'b01000, 5'b00101, 5'b10001, mk5(0,0,0,0,2), "stray_done"));
        tbl.push_back(V(5'b01101, t_none, 5'b00000, 5'b00101, 5'b10001, mk5(0,0,0,0,2), "none_req"));
        tbl.push_back(V(5'b01000, t_none, 5'b00101, 5'b00000, 5'b00000, '0, "par_done"));
        tbl.push_back(V(5'b01000, t_none, 5'b00000, 5'b00000, 5'b00000, '0, "none_never"));
        // Two outputs allocated ahead of the reset sequence
        tbl.push_back(V(5'b00110, t_rst, 5'b00000, 5'b00110, 5'b00011, mk5(2,1,0,0,0), "pre_reset"));

        // Power-on reset
        reset_n = 1'b0;
        apply_inputs(5'b00000, '0, 5'b00000);
        repeat (2) @(posedge clk);
        #1;
        push_exp(5'b00000, 5'b00000, '0, 1'b1, "reset_state");
        compare_pop();
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[k]) begin
            run_vec(tbl[k]);
        end

        // Asynchronous reset while N and E are allocated: outputs clear before any edge
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        push_exp(5'b00000, 5'b00000, '0, 1'b1, "async_reset");
        compare_pop();
        // Requests held across reset: E pointer must restart at 0 (old pointer 2 would pick 3)
        apply_inputs(5'b01001, t_ee, 5'b00000);
        @(negedge clk);
        reset_n = 1'b1;
        push_exp(5'b00001, 5'b00010, mk5(0,0,0,0,0), 1'b0, "post_reset_grant");
        @(posedge clk);
        #1;
        compare_pop();
        run_vec(V(5'b00000, t_ee, 5'b00001, 5'b00000, 5'b00000, '0, "post_reset_done"));

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_switch_allocator
`default_nettype wire

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, meaning the number of router input units and output ports (N, E, S, W, LOCAL).
REQ-002 SHALL have parameter SEL_W, default $clog2(NUM_PORTS), meaning the width of each crossbar select field.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL have port i_switch_req, input, NUM_PORTS bits: per-input switch request, held high by each input unit until acknowledged.
REQ-006 SHALL have port i_target_port, input, NUM_PORTS x PORT_t: the requested output port of each input.
REQ-007 SHALL have port i_packet_done, input, NUM_PORTS bits: per-input one-cycle pulse marking tail flit forwarded.
REQ-008 SHALL have port o_switch_ack, output, NUM_PORTS bits: per-input grant, held high while that input owns its output.
REQ-009 SHALL have port o_xbar_sel, output, NUM_PORTS x SEL_W: per output, the index of the owning input.
REQ-010 SHALL have port o_out_valid, output, NUM_PORTS bits: per output, high while the output is allocated.

Function
REQ-011 SHALL keep one two-state FSM per output port: FREE and ALLOCATED.
REQ-012 SHALL treat input i as requesting output j when i_switch_req[i]=1, i_target_port[i]=j, i_target_port[i]!=NONE_PORT, and o_switch_ack[i]=0.
REQ-013 SHALL, for an output in FREE, pick exactly one requester by round-robin starting at that output's priority pointer.
REQ-014 SHALL register the winner one cycle later: the request is sampled at edge t, and ack, sel, and valid are high after edge t+1.
REQ-015 SHALL, on a grant, move the output to ALLOCATED and set its pointer to winner+1 modulo NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
REQ-016 SHALL never change an ALLOCATED output's grant except on release.
REQ-017 SHALL release output j when its owner pulses i_packet_done, or when the owner drops i_switch_req (abort); ack and valid clear at the next edge.
REQ-018 SHALL give a released output at least one FREE cycle; re-grant occurs no earlier than two edges after the release pulse.
REQ-019 SHALL let different outputs grant in the same cycle, and each input SHALL hold at most one grant.
REQ-020 SHALL ignore i_packet_done from an input that holds no grant.
REQ-021 SHALL hold o_xbar_sel[j] at its last value while output j is FREE; it is qualified by o_out_valid[j].
REQ-022 SHALL leave losing requests pending, with no loss and no extra handshake.

Reset
REQ-023 SHALL, on reset_n low, asynchronously force o_switch_ack=0, o_out_valid=0, o_xbar_sel=0, every FSM to FREE, and every pointer to 0.
REQ-024 SHALL, on reset asserted mid-packet, drop all grants; requests still held after reset re-arbitrate from pointer 0.

Structure
REQ-025 SHALL take PORT_t, NONE_PORT, and the port count from router_pkg; SW_ALLOC_STATE_t (FREE/ALLOCATED) SHALL be added to router_pkg.
REQ-026 SHALL instantiate one sub-module, rr_arbiter (NUM_PORTS-bit request, pointer in, one-hot grant out, combinational), once per output.

Verification
REQ-027 Single request: input 0 requests E at t -> ack[0]=1, valid[E]=1, sel[E]=0 after t+1; done pulse on input 0 -> all clear at the next edge.
REQ-028 Contention: inputs 1, 2, 3 request S together, pointer 0 -> grant order 1, 2, 3 over successive packets, each re-grant at least two edges after the prior done.
REQ-029 Wrap-around: pointer at 4, inputs 4 and 0 request W -> input 4 wins, pointer becomes 0, input 0 wins next.
REQ-030 Parallel: inputs 0->N, 1->E, 2->LOCAL in the same cycle -> all three acked at the same edge, with sel values 0, 1, 2.
REQ-031 Abort and no-op: owner drops its request without done -> output freed; done from an ungranted input -> no state change; NONE_PORT request -> never acked.
REQ-032 Reset: assert reset_n low while two outputs are ALLOCATED -> ack, valid, and sel are 0 immediately; release reset with requests held -> grants from pointer 0.
